// File: rtl/byte_bus_pkg.sv
// Shared types for the byte-serialising CPU bus bridge and its address decoder.
package byte_bus_pkg;

    localparam int BUS_W = 32;

    localparam logic [2:0] BHW_BYTE = 3'b001;
    localparam logic [2:0] BHW_HALF = 3'b010;
    localparam logic [2:0] BHW_WORD = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_t;

    // The size code doubles as the byte count.
    typedef struct packed {
        logic [BUS_W-1:0] addr;
        logic [BUS_W-1:0] data;
        logic             wr;
        logic [2:0]       n;
    } bus_req_t;

    function automatic logic bhw_legal(input logic [2:0] bhw);
        return (bhw == BHW_BYTE) || (bhw == BHW_HALF) || (bhw == BHW_WORD);
    endfunction

endpackage

// File: rtl/byte_bus_decoder.sv
// Combinational region decoder: (addr & mask_k) == base_k, lowest index wins on overlap.
module byte_bus_decoder import byte_bus_pkg::*; #(
    parameter int                       N_SLAVES    = 6,
    parameter logic [N_SLAVES*32-1:0]   REGION_BASE = '0,
    parameter logic [N_SLAVES*32-1:0]   REGION_MASK = '0
) (
    input  logic [BUS_W-1:0]    addr,
    output logic [N_SLAVES-1:0] sel,
    output logic                hit
);

    logic [N_SLAVES-1:0] raw;

    for (genvar k = 0; k < N_SLAVES; k++) begin : g_region
        assign raw[k] = (addr & REGION_MASK[32*k +: 32]) == REGION_BASE[32*k +: 32];
    end

    // Isolate the lowest set bit so overlapping regions resolve to the lower index.
    assign sel = raw & (~raw + N_SLAVES'(1));
    assign hit = |raw;

endmodule

// File: rtl/byte_bus_bridge.sv
// CPU bus to byte-wide slave bridge: splits 1/2/4-byte transfers into per-byte
// request/done handshakes with per-byte decode, watchdog and error response.
module byte_bus_bridge import byte_bus_pkg::*; #(
    parameter int                     N_SLAVES    = 6,
    parameter int                     SUB_ADDR_W  = 23,
    parameter logic [N_SLAVES*32-1:0] REGION_BASE = {32'h0400_0020, 32'h0400_0010, 32'h0400_0000,
                                                     32'h0200_0000, 32'h0100_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*32-1:0] REGION_MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0,
                                                     32'hFE00_0000, 32'hFFF0_0000, 32'hFFFF_C000},
    parameter int                     TIMEOUT     = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [BUS_W-1:0]        i_bus_data,
    input  logic [BUS_W-1:0]        i_bus_address,
    input  logic                    i_bus_DV,
    input  logic [2:0]              i_bhw,
    input  logic                    i_write_notread,
    output logic [BUS_W-1:0]        o_bus_data,
    output logic                    o_bus_DV,
    output logic                    o_bus_err,
    output logic                    o_bus_busy,
    output logic [N_SLAVES-1:0]     o_sub_request,
    output logic [SUB_ADDR_W-1:0]   o_sub_address,
    output logic [7:0]              o_sub_data,
    output logic                    o_sub_write,
    input  logic [N_SLAVES*8-1:0]   i_sub_data,
    input  logic [N_SLAVES-1:0]     i_sub_done
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t              state;
    bus_req_t            req;
    logic [2:0]          idx;
    logic [TW-1:0]       timer;
    logic [N_SLAVES-1:0] sel_r;
    logic [N_SLAVES-1:0] dec_sel;
    logic                dec_hit;
    logic [BUS_W-1:0]    acc;
    logic [BUS_W-1:0]    cur_addr;
    logic                done_sel;
    logic [7:0]          rd_byte;

    assign cur_addr = req.addr + BUS_W'(idx);

    byte_bus_decoder #(
        .N_SLAVES    (N_SLAVES),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_dec (
        .addr (cur_addr),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    always_comb begin
        done_sel = |(i_sub_done & sel_r);
        rd_byte  = '0;
        for (int k = 0; k < N_SLAVES; k++)
            if (sel_r[k]) rd_byte = rd_byte | i_sub_data[8*k +: 8];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            req           <= '0;
            idx           <= '0;
            timer         <= '0;
            sel_r         <= '0;
            acc           <= '0;
            o_bus_data    <= '0;
            o_bus_DV      <= 1'b0;
            o_bus_err     <= 1'b0;
            o_bus_busy    <= 1'b0;
            o_sub_request <= '0;
            o_sub_address <= '0;
            o_sub_data    <= '0;
            o_sub_write   <= 1'b0;
        end else begin
            o_bus_DV      <= 1'b0;
            o_bus_err     <= 1'b0;
            o_sub_request <= '0;
            case (state)
                ST_IDLE: if (i_bus_DV) begin
                    o_bus_busy <= 1'b1;
                    if (bhw_legal(i_bhw)) begin
                        req   <= '{addr: i_bus_address, data: i_bus_data,
                                   wr: i_write_notread, n: i_bhw};
                        acc   <= '0;
                        idx   <= '0;
                        timer <= '0;
                        state <= ST_DECODE;
                    end else begin
                        o_bus_DV   <= 1'b1;
                        o_bus_err  <= 1'b1;
                        o_bus_data <= '0;
                        state      <= ST_RESP;
                    end
                end
                // Completion is detected here rather than in WAIT, which gives the
                // success path its one extra cycle before the response.
                ST_DECODE: if (idx == req.n) begin
                    o_bus_DV   <= 1'b1;
                    o_bus_data <= req.wr ? '0 : acc;
                    state      <= ST_RESP;
                end else if (dec_hit) begin
                    sel_r         <= dec_sel;
                    o_sub_request <= dec_sel;
                    o_sub_address <= cur_addr[SUB_ADDR_W-1:0];
                    o_sub_data    <= req.data[{idx[1:0], 3'b000} +: 8];
                    o_sub_write   <= req.wr;
                    state         <= ST_REQ;
                end else begin
                    o_bus_DV   <= 1'b1;
                    o_bus_err  <= 1'b1;
                    o_bus_data <= '0;
                    state      <= ST_RESP;
                end
                ST_REQ: begin
                    timer <= TW'(1);
                    state <= ST_WAIT;
                end
                // done is checked before the watchdog so it wins a same-cycle tie.
                ST_WAIT: if (done_sel) begin
                    if (!req.wr) acc[{idx[1:0], 3'b000} +: 8] <= rd_byte;
                    idx   <= idx + 3'd1;
                    state <= ST_DECODE;
                end else if (timer == TW'(TIMEOUT)) begin
                    o_bus_DV   <= 1'b1;
                    o_bus_err  <= 1'b1;
                    o_bus_data <= '0;
                    state      <= ST_RESP;
                end else begin
                    timer <= timer + TW'(1);
                end
                ST_RESP: begin
                    o_bus_busy <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
